behave_adder: RTL and testbench
===============================

Name: behave_adder

Overview:
Parameterised N-bit binary adder with carry-in and carry-out, described behaviourally. Provides a zero-latency combinational result (Sum/Cout) plus a registered copy (Sum_q/Cout_q) with a valid qualifier. Serves as the datapath adder in arithmetic blocks and as the golden reference against structural adders (ripple, carry-lookahead).

Parameters:
N, 8, operand and sum width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock for the registered outputs
rst_n  input  1  asynchronous active-low reset
A  input  N  operand A, unsigned
B  input  N  operand B, unsigned
Cin  input  1  carry-in
in_valid  input  1  operands valid this cycle; gates the output register
Sum  output  N  combinational sum, (A+B+Cin) mod 2^N
Cout  output  1  combinational carry-out, bit N of A+B+Cin
Sum_q  output  N  registered Sum
Cout_q  output  1  registered Cout
out_valid  output  1  Sum_q/Cout_q hold a result captured from a valid input

Behaviour:
- Arithmetic: {Cout,Sum} = A + B + Cin, computed at N+1 bits; no truncation before the carry is taken. Unsigned interpretation only.
- Sum/Cout: purely combinational, zero latency, independent of clk and rst_n.
  - Settle within the same delta cycle as any change on A, B or Cin.
  - No latches; no X on outputs when all inputs are known.
- Registered path: on each rising clk edge:
  - if in_valid=1: Sum_q<=Sum, Cout_q<=Cout, out_valid<=1.
  - if in_valid=0: Sum_q/Cout_q hold their value; out_valid<=0.
  - Latency from in_valid to out_valid: 1 cycle. Back-to-back valids every cycle are supported; there is no backpressure.
- Reset (rst_n=0, asynchronous assert): Sum_q=0, Cout_q=0, out_valid=0 immediately, without waiting for clk. Deassertion is synchronous to the design; the first capture happens on the first rising edge with rst_n=1.
- Reset mid-operation: a pending result is discarded. Combinational Sum/Cout keep tracking the inputs during reset.
- Boundary cases:
  - All-ones + 1 wraps to Sum=0 with Cout=1.
  - All-ones + all-ones + Cin=1 gives Sum=all-ones, Cout=1.
  - 0+0+0 gives 0 with Cout=0.
- Flags (Zero/Ovf, below): combinational, derived from Sum/Cout.

Optional Feature:
Macro ADDER_FLAGS_EN.
- Defined: adds outputs Zero (1 bit) and Ovf (1 bit).
  - Zero = (Sum==0).
  - Ovf = signed overflow, i.e. A[N-1]==B[N-1] and Sum[N-1]!=A[N-1].
  - Registered copies Zero_q and Ovf_q follow the same capture/reset rules as Sum_q; both reset to 0.
- Undefined: these four ports do not exist; all other behaviour is identical.

Test Plan:
- N=8; A=15, B=1, Cin=0 -> Sum=16 (00010000), Cout=0; with in_valid=1 for one cycle, Sum_q=16 and out_valid=1 after one edge.
- A=255, B=1, Cin=0 -> Sum=0, Cout=1 (wrap); if flags enabled, Zero=1, Ovf=0.
- A=170, B=85, Cin=1 -> Sum=0, Cout=1; A=255, B=255, Cin=1 -> Sum=255, Cout=1.
- A=0, B=0, Cin=0 -> Sum=0, Cout=0; A=127, B=1 with flags enabled -> Sum=128, Ovf=1.
- Assert rst_n=0 between clock edges while out_valid=1 -> Sum_q=0, Cout_q=0, out_valid=0 immediately; Sum/Cout still track the inputs.
- Stream 100 random operand pairs with in_valid toggling -> Sum/Cout always match the N+1-bit reference; Sum_q lags by exactly one valid cycle and holds when in_valid=0.

Source files
------------

// File: rtl/behave_adder.sv
// rtl/behave_adder.sv - N-bit behavioural adder with combinational and registered results
// Optional Zero/Ovf flags (and registered copies) are built when ADDER_FLAGS_EN is defined.
module behave_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         in_valid,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic [N-1:0] Sum_q,
    output logic         Cout_q,
    output logic         out_valid
`ifdef ADDER_FLAGS_EN
    ,
    output logic         Zero,
    output logic         Ovf,
    output logic         Zero_q,
    output logic         Ovf_q
`endif
);

    // Widen before adding so the carry out of bit N-1 is never truncated.
    logic [N:0] full_sum;

    assign full_sum = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
    assign Sum      = full_sum[N-1:0];
    assign Cout     = full_sum[N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum_q     <= '0;
            Cout_q    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum_q  <= Sum;
                Cout_q <= Cout;
            end
        end
    end

`ifdef ADDER_FLAGS_EN
    // Signed overflow: like-signed operands producing a result of the other sign.
    assign Zero = (Sum == '0);
    assign Ovf  = (A[N-1] == B[N-1]) && (Sum[N-1] != A[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Zero_q <= 1'b0;
            Ovf_q  <= 1'b0;
        end else if (in_valid) begin
            Zero_q <= Zero;
            Ovf_q  <= Ovf;
        end
    end
`endif

endmodule

// File: tb/tb_behave_adder.sv
// tb/tb_behave_adder.sv - table-driven and random checks of behave_adder
module tb_behave_adder;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Cin;
    logic         in_valid;
    logic [N-1:0] Sum;
    logic         Cout;
    logic [N-1:0] Sum_q;
    logic         Cout_q;
    logic         out_valid;
`ifdef ADDER_FLAGS_EN
    logic         Zero;
    logic         Ovf;
    logic         Zero_q;
    logic         Ovf_q;
`endif

    int checks   = 0;
    int failures = 0;

    behave_adder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Sum_q     (Sum_q),
        .Cout_q    (Cout_q),
        .out_valid (out_valid)
`ifdef ADDER_FLAGS_EN
        ,
        .Zero      (Zero),
        .Ovf       (Ovf),
        .Zero_q    (Zero_q),
        .Ovf_q     (Ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] exp_sum_q;
    logic       exp_cout_q;
    logic [8:0] ref_full;
    logic       v;

    initial begin
        vecs[0] = '{8'd15,  8'd1,   1'b0, 8'd16,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'd170, 8'd85,  1'b1, 8'd0,   1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1, 1'b1};
        vecs[7] = '{8'd100, 8'd50,  1'b1, 8'd151, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        A        = 8'd3;
        B        = 8'd4;
        Cin      = 1'b0;
        in_valid = 1'b1;
        #2;
        check("reset_sum_q", 64'(Sum_q), 64'd0);
        check("reset_cout_q", 64'(Cout_q), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_comb_sum", 64'(Sum), 64'd7);
        @(posedge clk);
        #1;
        check("reset_hold_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            A        = vecs[i].a;
            B        = vecs[i].b;
            Cin      = vecs[i].cin;
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_sum", i), 64'(Sum), 64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(Cout), 64'(vecs[i].cout));
`ifdef ADDER_FLAGS_EN
            check($sformatf("vec%0d_zero", i), 64'(Zero), 64'(vecs[i].zero));
            check($sformatf("vec%0d_ovf", i), 64'(Ovf), 64'(vecs[i].ovf));
`endif
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_sum_q", i), 64'(Sum_q), 64'(vecs[i].sum));
            check($sformatf("vec%0d_cout_q", i), 64'(Cout_q), 64'(vecs[i].cout));
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'd1);
`ifdef ADDER_FLAGS_EN
            check($sformatf("vec%0d_zero_q", i), 64'(Zero_q), 64'(vecs[i].zero));
            check($sformatf("vec%0d_ovf_q", i), 64'(Ovf_q), 64'(vecs[i].ovf));
`endif
        end

        // Hold: registered copy of the last vector (100+50+1=151) must stay put.
        in_valid = 1'b0;
        A        = 8'd1;
        B        = 8'd2;
        Cin      = 1'b0;
        @(posedge clk);
        #1;
        check("hold_out_valid", 64'(out_valid), 64'd0);
        check("hold_sum_q", 64'(Sum_q), 64'd151);
        check("hold_comb_sum", 64'(Sum), 64'd3);

        // Capture 200+100=300 -> 44 carry 1, then reset mid-cycle.
        A        = 8'd200;
        B        = 8'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        check("pre_rst_sum_q", 64'(Sum_q), 64'd44);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum_q", 64'(Sum_q), 64'd0);
        check("async_rst_cout_q", 64'(Cout_q), 64'd0);
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        A = 8'd20;
        B = 8'd22;
        #1;
        check("rst_comb_sum", 64'(Sum), 64'd42);
        check("rst_comb_cout", 64'(Cout), 64'd0);
        @(posedge clk);
        #1;
        check("rst_no_capture", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_sum_q", 64'(Sum_q), 64'd42);
        check("post_rst_out_valid", 64'(out_valid), 64'd1);

        exp_sum_q  = 8'd42;
        exp_cout_q = 1'b0;
        for (int i = 0; i < 100; i++) begin
            A        = 8'($urandom_range(0, 255));
            B        = 8'($urandom_range(0, 255));
            Cin      = 1'($urandom_range(0, 1));
            v        = 1'($urandom_range(0, 1));
            in_valid = v;
            ref_full = {1'b0, A} + {1'b0, B} + {8'd0, Cin};
            #1;
            check($sformatf("rnd%0d_sum", i), 64'(Sum), 64'(ref_full[7:0]));
            check($sformatf("rnd%0d_cout", i), 64'(Cout), 64'(ref_full[8]));
            if (v) begin
                exp_sum_q  = ref_full[7:0];
                exp_cout_q = ref_full[8];
            end
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_out_valid", i), 64'(out_valid), 64'(v));
            check($sformatf("rnd%0d_sum_q", i), 64'(Sum_q), 64'(exp_sum_q));
            check($sformatf("rnd%0d_cout_q", i), 64'(Cout_q), 64'(exp_cout_q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
